// File: rtl/mux_2to1.sv
// 2:1 data multiplexer with a combinational result, its parity, a
// registered copy, a "registered copy is meaningful" flag and a
// saturating counter of clocked select transitions.
module mux_2to1 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_r,
  output logic             q_par,
  output logic             q_r_valid,
  output logic [CNT_W-1:0] sel_toggles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Even parity of a data word: XOR of all bits.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [WIDTH-1:0] q_s;
  logic             toggle_s;
  logic [WIDTH-1:0] q_r_r;
  logic             valid_r;
  logic             sel_d_r;
  logic [CNT_W-1:0] toggles_r;

  // Select the data input; an unknown select yields an unknown result
  // instead of silently favouring one input.
  always_comb begin
    q_s = {WIDTH{1'bx}};
    case (sel)
      1'b0:    q_s = a;
      1'b1:    q_s = b;
      default: q_s = {WIDTH{1'bx}};
    endcase
  end

  // A transition counts only once the registered side has left reset,
  // so the first edge after reset never registers a spurious toggle.
  always_comb begin
    toggle_s = 1'b0;
    if (valid_r && (sel != sel_d_r)) begin
      toggle_s = 1'b1;
    end else begin
      toggle_s = 1'b0;
    end
  end

  // Registered data path, valid flag and previous-select capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r_r   <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      sel_d_r <= 1'b0;
    end else begin
      q_r_r   <= q_s;
      valid_r <= 1'b1;
      sel_d_r <= sel;
    end
  end

  // Saturating select-transition counter; holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggles_r <= {CNT_W{1'b0}};
    end else if (toggle_s && (toggles_r != CNT_MAX)) begin
      toggles_r <= toggles_r + CNT_ONE;
    end else begin
      toggles_r <= toggles_r;
    end
  end

  assign q           = q_s;
  assign q_par       = even_parity(q_s);
  assign q_r         = q_r_r;
  assign q_r_valid   = valid_r;
  assign sel_toggles = toggles_r;

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: table-driven combinational vectors,
// hand-written registered/counter/reset sequences and a randomized run
// compared against a simple behavioural model.
module tb_mux_2to1;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic [31:0] q;
  logic [31:0] q_r;
  logic        q_par;
  logic        q_r_valid;
  logic [15:0] sel_toggles;

  // Narrow instance with a tiny counter so saturation is reachable.
  logic [7:0]  q_n;
  logic [7:0]  q_r_n;
  logic        q_par_n;
  logic        q_r_valid_n;
  logic [2:0]  sel_toggles_n;

  int checks;
  int errors;

  // Behavioural model state
  logic [31:0] m_qr;
  logic        m_valid;
  logic        m_sel_prev;
  int          m_cnt;
  int          m_cnt_n;

  mux_2to1 #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .q(q), .q_r(q_r), .q_par(q_par), .q_r_valid(q_r_valid),
    .sel_toggles(sel_toggles)
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(3)) dut_n (
    .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .sel(sel),
    .q(q_n), .q_r(q_r_n), .q_par(q_par_n), .q_r_valid(q_r_valid_n),
    .sel_toggles(sel_toggles_n)
  );

  // Clock runs only when enabled, otherwise held low.
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] x, input logic [31:0] y, input logic s);
    return s ? y : x;
  endfunction

  function automatic logic parity_of(input logic [31:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_qr = 32'd0; m_valid = 1'b0; m_sel_prev = 1'b0; m_cnt = 0; m_cnt_n = 0;
  endtask

  // Drive inputs, take one clock edge, advance the model, compare.
  task automatic step(input logic [31:0] na, input logic [31:0] nb, input logic ns);
    a = na; b = nb; sel = ns;
    @(posedge clk);
    if (m_valid && (ns != m_sel_prev)) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_n < 7) m_cnt_n++;
    end
    m_sel_prev = ns;
    m_qr = pick(na, nb, ns);
    m_valid = 1'b1;
    #1;
    chk("q", q, pick(na, nb, ns));
    chk("q_par", q_par, parity_of(pick(na, nb, ns)));
    chk("q_r", q_r, m_qr);
    chk("q_r_valid", q_r_valid, m_valid);
    chk("sel_toggles", sel_toggles, m_cnt);
    chk("sel_toggles_n", sel_toggles_n, m_cnt_n);
    chk("q_r_n", q_r_n, m_qr[7:0]);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] exp_q;
    logic        exp_par;
  } vec_t;

  vec_t vecs[12];

  initial begin
    checks = 0; errors = 0;
    clk = 1'b0; clk_en = 1'b0; rst = 1'b0;
    a = 32'd0; b = 32'd0; sel = 1'b0;
    model_reset();

    vecs[0]  = '{32'd1, 32'd2, 1'b0, 32'd1, 1'b1};
    vecs[1]  = '{32'd1, 32'd2, 1'b1, 32'd2, 1'b1};
    vecs[2]  = '{32'd3, 32'd4, 1'b0, 32'd3, 1'b0};
    vecs[3]  = '{32'd3, 32'd4, 1'b1, 32'd4, 1'b1};
    vecs[4]  = '{32'd5, 32'd6, 1'b0, 32'd5, 1'b0};
    vecs[5]  = '{32'd5, 32'd6, 1'b1, 32'd6, 1'b0};
    vecs[6]  = '{32'd7, 32'd8, 1'b0, 32'd7, 1'b1};
    vecs[7]  = '{32'd7, 32'd8, 1'b1, 32'd8, 1'b1};
    vecs[8]  = '{32'd9, 32'd10, 1'b0, 32'd9, 1'b0};
    vecs[9]  = '{32'd9, 32'd10, 1'b1, 32'd10, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{32'd1, 32'hFFFF_FFFF, 1'b0, 32'd1, 1'b1};

    // Asynchronous reset with no clock running
    #1 rst = 1'b1;
    #1;
    chk("rst_q_r", q_r, 32'd0);
    chk("rst_valid", q_r_valid, 1'b0);
    chk("rst_toggles", sel_toggles, 16'd0);
    rst = 1'b0;

    // Combinational vectors, clock and reset idle
    for (int i = 0; i < 12; i++) begin
      a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel;
      #20;
      chk("vec_q", q, vecs[i].exp_q);
      chk("vec_par", q_par, vecs[i].exp_par);
      chk("vec_q_r_idle", q_r, 32'd0);
    end

    // Registered path after reset release
    rst = 1'b1; #2;
    a = 32'd7; b = 32'd8; sel = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("pre_edge_q_r", q_r, 32'd0);
    chk("pre_edge_valid", q_r_valid, 1'b0);
    clk_en = 1'b1;
    step(32'd7, 32'd8, 1'b1);
    chk("first_edge_q_r", q_r, 32'd8);
    chk("first_edge_valid", q_r_valid, 1'b1);
    chk("first_edge_toggles", sel_toggles, 16'd0);

    // Five alternating select edges after valid
    for (int i = 0; i < 5; i++) step(32'h1111_0000 + i, 32'h2222_0000 + i, i[0] == 1'b0 ? 1'b0 : 1'b1);
    chk("five_toggles", sel_toggles, 16'd5);

    // Drive the narrow counter to all-ones and beyond
    for (int i = 0; i < 6; i++) step(32'hA5A5_A5A5, 32'h5A5A_5A5A, ~sel);
    chk("sat_all_ones", sel_toggles_n, 3'd7);
    step(32'd3, 32'd4, ~sel);
    chk("sat_hold", sel_toggles_n, 3'd7);

    // Randomized run
    for (int i = 0; i < 200; i++) step($urandom, $urandom, 1'($urandom_range(0, 1)));

    // Mid-operation reset between edges
    step(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q_r", q_r, 32'd0);
    chk("mid_rst_valid", q_r_valid, 1'b0);
    chk("mid_rst_toggles", sel_toggles, 16'd0);
    chk("mid_rst_q", q, 32'hCAFE_F00D);
    sel = 1'b0; #1;
    chk("mid_rst_q_track", q, 32'hDEAD_BEEF);
    #1 rst = 1'b0;
    model_reset();
    step(32'd11, 32'd12, 1'b1);
    step(32'd13, 32'd14, 1'b0);
    step(32'd15, 32'd16, 1'b1);
    chk("post_rst_toggles", sel_toggles, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_2to1.md
MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 Parameter WIDTH, default 32: data width of a, b, q, q_r.
REQ-002 Parameter CNT_W, default 16: width of sel_toggles.
REQ-003 Port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port a, input, WIDTH bits: data input, selected when sel=0.
REQ-006 Port b, input, WIDTH bits: data input, selected when sel=1.
REQ-007 Port sel, input, 1 bit: select; 0 selects a, 1 selects b.
REQ-008 Port q, output, WIDTH bits: combinational mux result.
REQ-009 Port q_r, output, WIDTH bits: q registered on clk.
REQ-010 Port q_par, output, 1 bit: combinational even parity of q (XOR of all q bits).
REQ-011 Port q_r_valid, output, 1 bit: high once q_r holds a sampled value since reset.
REQ-012 Port sel_toggles, output, CNT_W bits: count of clocked sel transitions since reset.

Function
REQ-013 q SHALL equal a when sel=0 and b when sel=1, purely combinationally, with zero clock latency.
REQ-014 q and q_par SHALL NOT depend on clk or rst; they SHALL be correct with clk and rst tied low or left unconnected.
REQ-015 q SHALL follow any change on a, b or sel within the same simulation time step, with no storage and no latch inferred.
REQ-016 When sel is X or Z, q SHALL be X in simulation; no priority default is applied.
REQ-017 On each rising clk edge with rst low, q_r SHALL load the current q; latency from a, b or sel to q_r is 1 cycle.
REQ-018 q_r_valid SHALL go high on the first rising clk edge after rst deasserts and stay high until the next reset.
REQ-019 The block SHALL hold an internal register sel_d that captures sel on every rising clk edge.
REQ-020 sel_toggles SHALL increment by 1 on a rising edge when sel differs from sel_d and q_r_valid is high.
REQ-021 sel_toggles SHALL saturate at all-ones and SHALL NOT wrap to zero.
REQ-022 Simultaneous changes of a, b and sel SHALL produce q equal to the newly selected input, with no intermediate value required.

Reset
REQ-023 rst high SHALL immediately, without waiting for clk, force the following registered values: q_r=0, q_r_valid=0, sel_d=0, sel_toggles=0.
REQ-024 Reset asserted mid-operation SHALL clear the registered outputs asynchronously, and q SHALL continue to track a, b and sel throughout.
REQ-025 After rst deasserts, registers SHALL resume normal update on the next rising clk edge.

Verification
REQ-026 The bench SHALL apply a=1, b=2, sel=0 and require q=1; then sel=1 and require q=2.
REQ-027 The bench SHALL repeat REQ-026 with these pairs, requiring q=a when sel=0 and q=b when sel=1, each step held 20 ns with clk/rst idle:
- a=3, b=4
- a=5, b=6
- a=7, b=8
- a=9, b=10
REQ-028 The bench SHALL check q_par: a=32'hFFFF_FFFF with sel=0 requires q_par=0; a=1 requires q_par=1.
REQ-029 Registered path: with clocking, after reset release, a=7, b=8, sel=1 requires q_r=0 before the first edge and q_r=8 after it, with q_r_valid=1.
REQ-030 Toggle counting: sel alternating every cycle for 5 edges after valid requires sel_toggles=5; forcing the counter to all-ones then toggling requires it to remain all-ones.
REQ-031 Mid-operation reset: asserting rst between clock edges requires q_r=0, q_r_valid=0 and sel_toggles=0 immediately, while q still equals the selected input.
